// File: rtl/pwm_cap_pkg.sv
// Shared definitions for the PWM capture block.
//   CW_DEF      : default width of the period/high-time counters and outputs
//   TIMEOUT_DEF : default number of clk cycles without a rising edge before
//                 the input is declared lost
//   state_t     : capture FSM encoding
package pwm_cap_pkg;

  localparam int          CW_DEF      = 32;
  localparam logic [31:0] TIMEOUT_DEF = 32'd4_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Brings an asynchronous input into the clk domain and flags its edges.
// Ports:
//   clk   : system clock
//   rst   : asynchronous active-high reset, clears all three flops
//   din   : asynchronous input
//   level : synchronized level (second flop)
//   rise  : one-cycle flag, synchronized level went 0 -> 1
//   fall  : one-cycle flag, synchronized level went 1 -> 0
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // s1/s2 resolve metastability; s3 is the previous synchronized value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// Measures the period (rising edge to rising edge) and the high time of an
// external PWM waveform in clk cycles.
// Ports:
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   en     : capture enable; low returns to idle and keeps the last result
//   pwm_in : asynchronous PWM input
//   period : last measured period, saturating at 2^CW-1
//   duty   : last measured high time within that period, saturating
//   valid  : one-cycle pulse when period/duty update
//   lost   : level; no rising edge for TIMEOUT cycles, or none since enable
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int          CW      = CW_DEF,
  parameter logic [31:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          pwm_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] duty,
  output logic          valid,
  output logic          lost
);

  state_t state, state_nx;

  logic          lvl, rise, fall_unused;
  logic [CW-1:0] cnt_p, cnt_h;
  // Cycles since the last rise (or since arming). Kept separate from cnt_p so
  // the timeout still works when CW is too narrow to count up to TIMEOUT.
  logic [31:0]   cnt_w;
  logic          tmo;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  sync_edge u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (pwm_in),
    .level (lvl),
    .rise  (rise),
    .fall  (fall_unused)
  );

  assign tmo = (cnt_w >= TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // A rise takes priority over a coincident timeout.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (en) state_nx = ST_ARM;
      ST_ARM: begin
        if (!en)       state_nx = ST_IDLE;
        else if (rise) state_nx = ST_MEAS;
      end
      ST_MEAS: begin
        if (!en)              state_nx = ST_IDLE;
        else if (!rise && tmo) state_nx = ST_ARM;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p  <= '0;
      cnt_h  <= '0;
      cnt_w  <= '0;
      period <= '0;
      duty   <= '0;
      valid  <= 1'b0;
      lost   <= 1'b1;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        // Results are held; only the partial measurement is dropped.
        cnt_p <= '0;
        cnt_h <= '0;
        cnt_w <= '0;
        lost  <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            cnt_p <= '0;
            cnt_h <= '0;
            cnt_w <= '0;
            lost  <= 1'b1;
          end
          ST_ARM: begin
            if (rise) begin
              // The rise cycle is the first cycle of the new period and is high.
              cnt_p <= CW'(1);
              cnt_h <= CW'(1);
              cnt_w <= 32'd1;
            end else if (tmo) begin
              cnt_w  <= '0;
              lost   <= 1'b1;
              period <= '0;
              duty   <= '0;
            end else begin
              cnt_w <= cnt_w + 32'd1;
            end
          end
          ST_MEAS: begin
            if (rise) begin
              period <= cnt_p;
              duty   <= cnt_h;
              valid  <= 1'b1;
              lost   <= 1'b0;
              cnt_p  <= CW'(1);
              cnt_h  <= CW'(1);
              cnt_w  <= 32'd1;
            end else if (tmo) begin
              lost   <= 1'b1;
              period <= '0;
              duty   <= '0;
              cnt_p  <= '0;
              cnt_h  <= '0;
              cnt_w  <= '0;
            end else begin
              cnt_p <= sat_inc(cnt_p);
              if (lvl) cnt_h <= sat_inc(cnt_h);
              cnt_w <= cnt_w + 32'd1;
            end
          end
          default: begin
            cnt_p <= '0;
            cnt_h <= '0;
            cnt_w <= '0;
            lost  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

  typedef struct packed {
    logic [31:0] p;
    logic [31:0] d;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        pwm_in;
  logic [31:0] period32, duty32;
  logic        valid32, lost32;
  logic [7:0]  period8, duty8;
  logic        valid8, lost8;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_push  = 0;
  int   n_pop32 = 0;
  exp_t q32[$];
  exp_t q8[$];

  // Bench model of the capture: a rise only closes a period if a previous
  // rise was seen since enable/reset/timeout.
  bit have_prev = 0;
  int prev_p    = 0;
  int prev_h    = 0;

  pwm_capture #(.CW(32), .TIMEOUT(32'd1000)) dut (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
    .period(period32), .duty(duty32), .valid(valid32), .lost(lost32)
  );

  pwm_capture #(.CW(8), .TIMEOUT(32'd1000)) dut8 (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
    .period(period8), .duty(duty8), .valid(valid8), .lost(lost8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] sat8(input int v);
    return (v > 255) ? 32'd255 : v[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int p, input int h);
    exp_t e;
    e.p = p[31:0];
    e.d = h[31:0];
    q32.push_back(e);
    e.p = sat8(p);
    e.d = sat8(h);
    q8.push_back(e);
    n_push++;
  endtask

  // Drive a rising edge; close the previous period in the model if one is open.
  task automatic start_rise(input int hi, input int lo);
    pwm_in = 1'b1;
    if (have_prev) push_exp(prev_p, prev_h);
    have_prev = 1;
    prev_p    = hi + lo;
    prev_h    = hi;
  endtask

  // One PWM period, entered and left at a falling clk edge.
  task automatic wave(input int hi, input int lo, input bit chk_lat = 0);
    bit expect_valid;
    expect_valid = have_prev;
    start_rise(hi, lo);
    if (chk_lat && expect_valid) begin
      repeat (2) @(negedge clk);
      check("latency_valid_early", {31'd0, valid32}, 32'd0);
      @(negedge clk);
      check("latency_valid_3rd_edge", {31'd0, valid32}, 32'd1);
      repeat (hi - 3) @(negedge clk);
    end else begin
      repeat (hi) @(negedge clk);
    end
    pwm_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Scoreboard: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (valid32) begin
      check("valid32_expected", {31'd0, (q32.size() != 0)}, 32'd1);
      if (q32.size() != 0) begin
        e = q32.pop_front();
        n_pop32++;
        check("period32", period32, e.p);
        check("duty32", duty32, e.d);
        check("lost32_on_valid", {31'd0, lost32}, 32'd0);
      end
    end
    if (valid8) begin
      check("valid8_expected", {31'd0, (q8.size() != 0)}, 32'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        check("period8", {24'd0, period8}, e.p);
        check("duty8", {24'd0, duty8}, e.d);
      end
    end
  end

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period", period32, 32'd0);
    check("rst_duty", duty32, 32'd0);
    check("rst_valid", {31'd0, valid32}, 32'd0);
    check("rst_lost", {31'd0, lost32}, 32'd1);
    check("rst_lost8", {31'd0, lost8}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_lost", {31'd0, lost32}, 32'd1);
    en = 1'b1;
    @(negedge clk);

    // 100-cycle period, 30 high.
    wave(30, 70);
    check("armed_lost_before_2nd_rise", {31'd0, lost32}, 32'd1);
    wave(30, 70, 1'b1);
    wave(30, 70);
    wave(30, 70);
    check("steady_lost", {31'd0, lost32}, 32'd0);
    check("steady_period", period32, 32'd100);
    check("steady_duty", duty32, 32'd30);

    // Input held low after a final rise: lost only after 1000 cycles.
    wave(30, 870);
    check("pre_timeout_lost", {31'd0, lost32}, 32'd0);
    check("pre_timeout_period", period32, 32'd100);
    repeat (200) @(negedge clk);
    check("low_timeout_lost", {31'd0, lost32}, 32'd1);
    check("low_timeout_period", period32, 32'd0);
    check("low_timeout_duty", duty32, 32'd0);
    check("low_timeout_period8", {24'd0, period8}, 32'd0);
    have_prev = 0;

    // 200/50 then 150/149 with no intermediate value.
    wave(50, 150);
    wave(50, 150);
    wave(50, 150);
    wave(149, 1);
    wave(149, 1);
    wave(149, 1);

    // Input held high: same result as held low.
    start_rise(1200, 0);
    repeat (900) @(negedge clk);
    check("pre_high_timeout_period", period32, 32'd150);
    check("pre_high_timeout_duty", duty32, 32'd149);
    repeat (200) @(negedge clk);
    check("high_timeout_lost", {31'd0, lost32}, 32'd1);
    check("high_timeout_period", period32, 32'd0);
    check("high_timeout_duty", duty32, 32'd0);
    have_prev = 0;
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);

    // Enable dropped mid-period: results held, lost raised.
    wave(30, 70);
    wave(30, 70);
    start_rise(30, 70);
    repeat (10) @(negedge clk);
    en = 1'b0;
    have_prev = 0;
    @(negedge clk);
    check("en_drop_lost", {31'd0, lost32}, 32'd1);
    check("en_drop_period", period32, 32'd100);
    check("en_drop_duty", duty32, 32'd30);
    repeat (20) @(negedge clk);
    pwm_in = 1'b0;
    repeat (50) @(negedge clk);
    check("idle_hold_period", period32, 32'd100);
    en = 1'b1;
    @(negedge clk);
    wave(40, 80);
    wave(40, 80);
    wave(40, 80);

    // Asynchronous reset between rises.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_period", period32, 32'd0);
    check("async_rst_duty", duty32, 32'd0);
    check("async_rst_lost", {31'd0, lost32}, 32'd1);
    check("async_rst_period8", {24'd0, period8}, 32'd0);
    #1 rst = 1'b0;
    have_prev = 0;
    @(negedge clk);
    wave(60, 90);
    wave(60, 90);
    wave(60, 90);

    // 300-cycle period: saturates in the 8-bit instance only.
    wave(50, 250);
    wave(50, 250);
    wave(50, 250);
    check("sat_period8", {24'd0, period8}, 32'd255);
    check("sat_duty8", {24'd0, duty8}, 32'd50);
    check("wide_period32", period32, 32'd300);

    repeat (10) @(negedge clk);
    check("all_valids_seen32", q32.size(), 32'd0);
    check("all_valids_seen8", q8.size(), 32'd0);
    check("valid_count32", n_pop32, n_push);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter: CW, 32, width of the period and high-time counters and outputs.
REQ-002 Parameter: TIMEOUT, 32'd4_000_000, clk cycles without a rising edge before the signal is declared lost.
REQ-003 Port: clk  input  1  system clock; all state is on its rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: en  input  1  capture enable; low forces idle.
REQ-006 Port: pwm_in  input  1  external PWM waveform; asynchronous to clk.
REQ-007 Port: period  output  CW  last measured period in clk cycles, rising edge to rising edge.
REQ-008 Port: duty  output  CW  last measured high time in clk cycles within that period.
REQ-009 Port: valid  output  1  one-cycle pulse when period/duty update.
REQ-010 Port: lost  output  1  level; no rising edge for TIMEOUT cycles, or no edge yet since enable.

Function
REQ-011 pwm_in SHALL pass through a 2-flop synchronizer; a third flop holds the previous synchronized value; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-012 FSM states SHALL be IDLE, ARM, MEAS.
REQ-013 IDLE: counters held at 0; lost=1; transitions to ARM when en=1.
REQ-014 ARM: waits for the first rise; on rise, cnt_p and cnt_h SHALL load 1 and the state SHALL go to MEAS; no valid is issued.
REQ-015 MEAS: cnt_p SHALL increment every cycle; cnt_h SHALL increment every cycle in which s2=1; both SHALL saturate at 2^CW-1.
REQ-016 MEAS on rise: period<=cnt_p, duty<=cnt_h, valid=1 for exactly that cycle, lost<=0, cnt_p<=1, cnt_h<=1.
REQ-017 Latency: valid SHALL be high in the cycle beginning at the 3rd rising clk edge after pwm_in is first sampled high.
REQ-018 Timeout: in ARM or MEAS, when cnt_p (or ARM wait counter) reaches TIMEOUT without a rise, lost<=1, period<=0, duty<=0, and the state returns to ARM; no valid is issued.
REQ-019 Constant-high input SHALL therefore produce lost=1 with period=duty=0, identical to constant-low.
REQ-020 en=0 in any state SHALL go to IDLE next cycle, clear counters, and hold period/duty at their last values; lost<=1.
REQ-021 A rise and a timeout in the same cycle SHALL be treated as a rise (measurement wins).
REQ-022 A pulse shorter than 1 clk cycle after synchronization is not required to be detected; one at least 2 cycles high and 2 low SHALL be measured exactly.
REQ-023 Outputs SHALL be registered; no combinational path from pwm_in or en to any output.

Reset
REQ-024 rst=1 SHALL immediately force: state=IDLE, synchronizer flops=0, cnt_p=cnt_h=0, period=0, duty=0, valid=0, lost=1.
REQ-025 Reset asserted mid-measurement SHALL discard the partial measurement; after release the first valid requires two rises.

Structure
REQ-026 Package pwm_cap_pkg SHALL hold the CW default, the TIMEOUT default and the FSM state encoding.
REQ-027 Sub-module sync_edge SHALL contain the 3-flop synchronizer and the rise/fall outputs, reset by rst.
REQ-028 pwm_capture SHALL contain the FSM, counters and output registers; target 150-250 lines total.

Verification
REQ-029 en=1, period 100 cycles, high 30 -> first valid after 2nd rise; period=100, duty=30, lost=0; repeats every 100 cycles.
REQ-030 TIMEOUT=1000, pwm_in held 0 after two valid periods -> lost=1, period=0, duty=0 at 1000 cycles after last rise; no valid.
REQ-031 Period 200/high 50, then switch to period 150/high 149 -> period/duty sequence 200/50, then 150/149 with no glitch value.
REQ-032 en dropped mid-period -> next cycle IDLE, lost=1, period/duty unchanged; re-enable -> first new valid after two rises.
REQ-033 rst pulsed between rises (asynchronously to clk) -> outputs 0, lost=1 immediately; measurement resumes correctly.
REQ-034 CW=8, TIMEOUT=1000, period 300 -> period saturates at 255, duty correct if <=255.
